// File: rtl/number_assembler.sv
// number_assembler: folds a stream of digit characters into an integer by
// Horner's rule (acc = acc*RADIX + digit) and reports it on fin.
//
// Parameters:
//   RES_W      result width (8..64)
//   RADIX      10 or 16
//   ASCII      1: dato is an ASCII character, 0: dato is a raw digit value
//   MAX_DIGITS maximum digits per number (1..31)
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   dato       input character / digit, valid with num_ready
//   num_ready  single-cycle digit strobe
//   fin        single-cycle end-of-number strobe
//   resultado  assembled value (held until the next report)
//   done       one-cycle pulse, the cycle after fin
//   err_code   0 ok, 1 invalid digit, 2 overflow / too many digits, 3 empty
//   digit_cnt  digits accepted for the last reported number
//   busy       high while a number is in progress or an error is latched
//
// Build option: define NUMASM_SIGNED_EN to accept a leading '-' (or 8'hFF
// when ASCII=0) and report a two's-complement result.
module number_assembler #(
    parameter int unsigned RES_W      = 32,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned ASCII      = 1,
    parameter int unsigned MAX_DIGITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       dato,
    input  logic             num_ready,
    input  logic             fin,
    output logic [RES_W-1:0] resultado,
    output logic             done,
    output logic [1:0]       err_code,
    output logic [4:0]       digit_cnt,
    output logic             busy
);

    if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
        $error("number_assembler: RADIX must be 10 or 16");
    end
    if (RES_W < 8 || RES_W > 64) begin : g_bad_width
        $error("number_assembler: RES_W must be 8..64");
    end
    if (MAX_DIGITS < 1 || MAX_DIGITS > 31) begin : g_bad_digits
        $error("number_assembler: MAX_DIGITS must be 1..31");
    end

    // Headroom so acc*16+15 never wraps before the limit compare.
    localparam int unsigned      EXT_W     = RES_W + 5;
    localparam logic [EXT_W-1:0] ONE       = {{(EXT_W-1){1'b0}}, 1'b1};
    localparam logic [EXT_W-1:0] RADIX_EXT = EXT_W'(RADIX);
    localparam logic [7:0]       RADIX_B   = 8'(RADIX);
    localparam logic [4:0]       MAX_D     = 5'(MAX_DIGITS);

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrDigit = 2'd1;
    localparam logic [1:0] ErrOvf   = 2'd2;
    localparam logic [1:0] ErrEmpty = 2'd3;

    typedef enum logic [1:0] {StIdle, StAccum, StError} state_e;

    state_e             state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         err_q, err_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic               done_q, done_d;
    logic [1:0]         errc_q, errc_d;
    logic [4:0]         dcnt_q, dcnt_d;

    logic [7:0]         digit_raw;
    logic               digit_ok;
    logic [EXT_W-1:0]   ext_val;
    logic [EXT_W-1:0]   limit;
    logic               take_sign;

`ifdef NUMASM_SIGNED_EN
    localparam logic [EXT_W-1:0] PosMax = (ONE << (RES_W - 1)) - ONE;
    localparam logic [EXT_W-1:0] NegMax = ONE << (RES_W - 1);

    logic neg_q, neg_d;

    // Sign is only a sign when it is the very first character.
    assign take_sign = ((ASCII != 0) ? (dato == 8'h2D) : (dato == 8'hFF))
                       && (state_q == StIdle) && !neg_q;
    assign limit     = neg_q ? NegMax : PosMax;
`else
    localparam logic [EXT_W-1:0] UMax = (ONE << RES_W) - ONE;

    assign take_sign = 1'b0;
    assign limit     = UMax;
`endif

    // Digit decode; anything unrecognised becomes 8'hFF, which is >= RADIX.
    always_comb begin
        digit_raw = 8'hFF;
        if (ASCII != 0) begin
            if (dato >= 8'h30 && dato <= 8'h39) begin
                digit_raw = dato - 8'h30;
            end else if (RADIX == 16 && dato >= 8'h61 && dato <= 8'h66) begin
                digit_raw = dato - 8'h57;
            end else if (RADIX == 16 && dato >= 8'h41 && dato <= 8'h46) begin
                digit_raw = dato - 8'h37;
            end
        end else begin
            digit_raw = dato;
        end
    end

    assign digit_ok = (digit_raw < RADIX_B);
    assign ext_val  = {5'b0, acc_q} * RADIX_EXT + {{(EXT_W-8){1'b0}}, digit_raw};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef NUMASM_SIGNED_EN
        neg_d   = neg_q;
`endif
        res_d   = res_q;
        errc_d  = errc_q;
        dcnt_d  = dcnt_q;
        done_d  = fin;

        // Fold the strobed character first so a same-cycle fin sees it.
        if (num_ready && state_q != StError) begin
            if (take_sign) begin
`ifdef NUMASM_SIGNED_EN
                neg_d = 1'b1;
`endif
            end else if (!digit_ok) begin
                state_d = StError;
                err_d   = ErrDigit;
            end else if (cnt_q == MAX_D || ext_val > limit) begin
                // Accumulator left untouched on overflow.
                state_d = StError;
                err_d   = ErrOvf;
            end else begin
                acc_d   = ext_val[RES_W-1:0];
                cnt_d   = cnt_q + 5'd1;
                state_d = StAccum;
            end
        end

        if (fin) begin
            if (state_d == StError) begin
                res_d  = '0;
                errc_d = err_d;
                dcnt_d = cnt_d;
            end else if (state_d == StIdle) begin
                res_d  = '0;
                errc_d = ErrEmpty;
                dcnt_d = 5'd0;
            end else begin
`ifdef NUMASM_SIGNED_EN
                res_d  = neg_d ? -acc_d : acc_d;
`else
                res_d  = acc_d;
`endif
                errc_d = ErrNone;
                dcnt_d = cnt_d;
            end
            state_d = StIdle;
            acc_d   = '0;
            cnt_d   = 5'd0;
            err_d   = ErrNone;
`ifdef NUMASM_SIGNED_EN
            neg_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= 5'd0;
            err_q   <= ErrNone;
            res_q   <= '0;
            done_q  <= 1'b0;
            errc_q  <= ErrNone;
            dcnt_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            res_q   <= res_d;
            done_q  <= done_d;
            errc_q  <= errc_d;
            dcnt_q  <= dcnt_d;
        end
    end

`ifdef NUMASM_SIGNED_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

    assign resultado = res_q;
    assign done      = done_q;
    assign err_code  = errc_q;
    assign digit_cnt = dcnt_q;
    assign busy      = (state_q == StAccum) || (state_q == StError);

endmodule

// File: tb/tb_number_assembler.sv
// Self-checking bench for number_assembler: a decimal instance and a hex
// instance, each with its own expectation queue checked on every done pulse.
module tb_number_assembler;

    typedef struct {
        logic [31:0] res;
        logic [1:0]  err;
        logic [4:0]  cnt;
        bit          chk_cnt;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  d_dato, h_dato;
    logic        d_nr, d_fin, h_nr, h_fin;
    logic [31:0] d_res, h_res;
    logic        d_done, h_done, d_busy, h_busy;
    logic [1:0]  d_err, h_err;
    logic [4:0]  d_cnt, h_cnt;

    exp_t q_d[$];
    exp_t q_h[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    number_assembler #(.RES_W(32), .RADIX(10), .ASCII(1), .MAX_DIGITS(10)) u_dec (
        .clk       (clk),
        .reset     (reset),
        .dato      (d_dato),
        .num_ready (d_nr),
        .fin       (d_fin),
        .resultado (d_res),
        .done      (d_done),
        .err_code  (d_err),
        .digit_cnt (d_cnt),
        .busy      (d_busy)
    );

    number_assembler #(.RES_W(32), .RADIX(16), .ASCII(1), .MAX_DIGITS(10)) u_hex (
        .clk       (clk),
        .reset     (reset),
        .dato      (h_dato),
        .num_ready (h_nr),
        .fin       (h_fin),
        .resultado (h_res),
        .done      (h_done),
        .err_code  (h_err),
        .digit_cnt (h_cnt),
        .busy      (h_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit sel, input logic [31:0] res, input logic [1:0] err,
                            input logic [4:0] cnt, input bit chkc);
        exp_t e;
        e.res     = res;
        e.err     = err;
        e.cnt     = cnt;
        e.chk_cnt = chkc;
        e.cyc     = cyc + 1;
        if (sel) q_h.push_back(e);
        else     q_d.push_back(e);
    endtask

    // One clock of stimulus on the selected instance; called just after a posedge.
    task automatic step(input bit sel, input logic [7:0] c, input bit nr, input bit f);
        if (sel) begin
            h_dato = c; h_nr = nr; h_fin = f;
        end else begin
            d_dato = c; d_nr = nr; d_fin = f;
        end
        @(posedge clk);
        #1;
        d_nr = 1'b0; d_fin = 1'b0; h_nr = 1'b0; h_fin = 1'b0;
    endtask

    // Send a string; fin either shares the last character's cycle or follows it.
    task automatic num(input bit sel, input string s, input bit fuse, input logic [31:0] res,
                       input logic [1:0] err, input logic [4:0] cnt, input bit chkc);
        int n = s.len();
        for (int i = 0; i < n; i++) begin
            if (fuse && i == n - 1) begin
                push_exp(sel, res, err, cnt, chkc);
                step(sel, s[i], 1'b1, 1'b1);
            end else begin
                step(sel, s[i], 1'b1, 1'b0);
            end
        end
        if (!fuse || n == 0) begin
            push_exp(sel, res, err, cnt, chkc);
            step(sel, 8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic check_report(input string who, input logic [31:0] res, input logic [1:0] err,
                                input logic [4:0] cnt, input exp_t e);
        chk({who, "_resultado"}, res, e.res);
        chk({who, "_err_code"}, err, e.err);
        if (e.chk_cnt) chk({who, "_digit_cnt"}, cnt, e.cnt);
        chk({who, "_latency"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (d_done) begin
            chk("dec_done_expected", q_d.size() > 0, 1);
            if (q_d.size() > 0) check_report("dec", d_res, d_err, d_cnt, q_d.pop_front());
        end
        if (h_done) begin
            chk("hex_done_expected", q_h.size() > 0, 1);
            if (q_h.size() > 0) check_report("hex", h_res, h_err, h_cnt, q_h.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        d_dato = 8'h00; d_nr = 1'b0; d_fin = 1'b0;
        h_dato = 8'h00; h_nr = 1'b0; h_fin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resultado", d_res, 0);
        chk("rst_done", d_done, 0);
        chk("rst_err_code", d_err, 0);
        chk("rst_digit_cnt", d_cnt, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_hex_resultado", h_res, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic number, then outputs must hold after the pulse.
        step(1'b0, "1", 1'b1, 1'b0);
        chk("busy_accum", d_busy, 1);
        num(1'b0, "23", 1'b0, 32'd123, 2'd0, 5'd3, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("hold_resultado", d_res, 123);
        chk("hold_done_low", d_done, 0);
        chk("idle_busy", d_busy, 0);

        // Overflow boundary.
        num(1'b0, "4294967296", 1'b0, 32'd0, 2'd2, 5'd0, 1'b0);
        num(1'b0, "4294967295", 1'b0, 32'hFFFF_FFFF, 2'd0, 5'd10, 1'b1);

        // Invalid digit latches; later digits ignored. Empty fin.
        num(1'b0, "7x5", 1'b0, 32'd0, 2'd1, 5'd0, 1'b0);
        num(1'b0, "", 1'b0, 32'd0, 2'd3, 5'd0, 1'b1);
        num(1'b0, "F", 1'b0, 32'd0, 2'd1, 5'd0, 1'b0);

        // Back-to-back fins, digit+fin same cycle, no dead cycle after fin.
        num(1'b0, "8", 1'b0, 32'd8, 2'd0, 5'd1, 1'b1);
        num(1'b0, "", 1'b0, 32'd0, 2'd3, 5'd0, 1'b1);
        num(1'b0, "12", 1'b1, 32'd12, 2'd0, 5'd2, 1'b1);
        num(1'b0, "3", 1'b1, 32'd3, 2'd0, 5'd1, 1'b1);

        // Too many digits, invalid digit folded with fin.
        num(1'b0, "00000000001", 1'b0, 32'd0, 2'd2, 5'd0, 1'b0);
        num(1'b0, "5a", 1'b1, 32'd0, 2'd1, 5'd0, 1'b0);

        // Asynchronous reset mid-number discards the partial value.
        step(1'b0, "9", 1'b1, 1'b0);
        step(1'b0, "9", 1'b1, 1'b0);
        chk("mid_busy", d_busy, 1);
        reset = 1'b0;
        #2;
        chk("async_busy", d_busy, 0);
        chk("async_err_code", d_err, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        num(1'b0, "5", 1'b0, 32'd5, 2'd0, 5'd1, 1'b1);

`ifdef NUMASM_SIGNED_EN
        num(1'b0, "-45", 1'b0, 32'hFFFF_FFD3, 2'd0, 5'd2, 1'b1);
        num(1'b0, "-2147483648", 1'b0, 32'h8000_0000, 2'd0, 5'd10, 1'b1);
        num(1'b0, "2147483648", 1'b0, 32'd0, 2'd2, 5'd0, 1'b0);
        num(1'b0, "-", 1'b0, 32'd0, 2'd3, 5'd0, 1'b1);
        num(1'b0, "4-", 1'b0, 32'd0, 2'd1, 5'd0, 1'b0);
`else
        num(1'b0, "-4", 1'b0, 32'd0, 2'd1, 5'd0, 1'b0);
`endif

        // Hex instance.
        num(1'b1, "Ff", 1'b1, 32'd255, 2'd0, 5'd2, 1'b1);
        num(1'b1, "A0", 1'b0, 32'd160, 2'd0, 5'd2, 1'b1);
        num(1'b1, "g", 1'b0, 32'd0, 2'd1, 5'd0, 1'b0);

        for (int i = 0; i < 10 && (q_d.size() > 0 || q_h.size() > 0); i++) begin
            @(posedge clk);
        end
        #1;
        chk("dec_reports_drained", q_d.size(), 0);
        chk("hex_reports_drained", q_h.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
